rf_wb_arbiter: RTL and testbench

Writeback arbiter for the dual-write-port register file. Each cycle it merges three result sources onto the register file's two write ports (`a`, `b`): in-order pipe A, in-order pipe B, and a long-latency source (divider or uncached load). The long-latency source uses a one-entry holding buffer and a starvation guard. The block also suppresses writes to r0 and drops long-latency results made stale by younger writes to the same register.

---
 rtl/rf_wb_pkg.sv | 25 ++
 rtl/rf_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  // Default number of blocked cycles a held long-latency result may wait.
  localparam int WB_STARVE_LIMIT = 8;

  // Default register address and data widths.
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Holding-buffer state.
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_HOLD  = 2'd1,
    WB_FORCE = 2'd2
  } wb_state_t;

  // One writeback request at the default widths.
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Merges pipe A, pipe B and a buffered long-latency result onto the two
// register-file write ports. Handles r0 suppression, stale-result kill and
// a starvation guard that steals port a for one cycle.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = WB_ADDR_W,
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pipe_a_valid,
  input  logic [ADDR_WIDTH-1:0] pipe_a_addr,
  input  logic [DATA_WIDTH-1:0] pipe_a_data,
  input  logic                  pipe_b_valid,
  input  logic [ADDR_WIDTH-1:0] pipe_b_addr,
  input  logic [DATA_WIDTH-1:0] pipe_b_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [ADDR_WIDTH-1:0] ll_addr,
  input  logic [DATA_WIDTH-1:0] ll_data,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] waddr_a,
  output logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] waddr_b,
  output logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  stall_req,
  output logic                  proto_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  wb_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] buf_addr_reg, buf_addr_next;
  logic [DATA_WIDTH-1:0] buf_data_reg, buf_data_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  proto_err_reg, proto_err_next;

  logic [CNT_W-1:0] cnt_inc;
  logic             hit_a, hit_b, kill;
  logic             take_a, take_b, ll_rdy;

  assign cnt_inc = cnt_reg + CNT_W'(1);

  // A younger pipe write to the held register makes the held result stale.
  assign hit_a = pipe_a_valid && (pipe_a_addr != '0) && (pipe_a_addr == buf_addr_reg);
  assign hit_b = pipe_b_valid && (pipe_b_addr != '0) && (pipe_b_addr == buf_addr_reg);
  assign kill  = hit_a || hit_b;

  // The stall depends only on registered state, never on inputs.
  assign stall_req = (state_reg == WB_FORCE);
  assign proto_err = proto_err_reg;

  // Next-state logic: capture, retire/kill decisions and starvation counting.
  always_comb begin
    state_next     = state_reg;
    buf_addr_next  = buf_addr_reg;
    buf_data_next  = buf_data_reg;
    cnt_next       = cnt_reg;
    proto_err_next = proto_err_reg;
    take_a         = 1'b0;
    take_b         = 1'b0;
    ll_rdy         = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        ll_rdy = 1'b1;
        if (ll_valid) begin
          buf_addr_next = ll_addr;
          buf_data_next = ll_data;
          cnt_next      = '0;
          // A result for r0 is accepted and silently discarded.
          state_next    = (ll_addr != '0) ? WB_HOLD : WB_IDLE;
        end
      end
      WB_HOLD: begin
        if (kill) begin
          state_next = WB_IDLE;
        end else if (!pipe_a_valid) begin
          take_a     = 1'b1;
          state_next = WB_IDLE;
        end else if (!pipe_b_valid) begin
          take_b     = 1'b1;
          state_next = WB_IDLE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == LIMIT_C) begin
            state_next = WB_FORCE;
          end
        end
      end
      WB_FORCE: begin
        if (pipe_a_valid) begin
          proto_err_next = 1'b1;
        end
        // A stale result is dropped even here; otherwise port a is seized.
        if (!kill) begin
          take_a = 1'b1;
        end
        state_next = WB_IDLE;
      end
      default: begin
        state_next = WB_IDLE;
      end
    endcase
  end

  // Port muxing: pipes pass straight through unless the buffer takes a port.
  always_comb begin
    we_a     = pipe_a_valid && (pipe_a_addr != '0);
    waddr_a  = pipe_a_addr;
    wdata_a  = pipe_a_data;
    we_b     = pipe_b_valid && (pipe_b_addr != '0);
    waddr_b  = pipe_b_addr;
    wdata_b  = pipe_b_data;
    ll_ready = ll_rdy;
    if (take_a) begin
      we_a    = 1'b1;
      waddr_a = buf_addr_reg;
      wdata_a = buf_data_reg;
    end
    if (take_b) begin
      we_b    = 1'b1;
      waddr_b = buf_addr_reg;
      wdata_b = buf_data_reg;
    end
    if (!rstn) begin
      we_a     = 1'b0;
      waddr_a  = '0;
      wdata_a  = '0;
      we_b     = 1'b0;
      waddr_b  = '0;
      wdata_b  = '0;
      ll_ready = 1'b0;
    end
  end

  // State, holding buffer, starve counter and sticky protocol error.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= WB_IDLE;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
      cnt_reg       <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      buf_addr_reg  <= buf_addr_next;
      buf_data_reg  <= buf_data_next;
      cnt_reg       <= cnt_next;
      proto_err_reg <= proto_err_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios, an age-based reference
// model compared on every falling edge, plus hand-computed literal checks.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int LIMIT = WB_STARVE_LIMIT;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pipe_a_valid = 1'b0, pipe_b_valid = 1'b0, ll_valid = 1'b0;
  logic [4:0]  pipe_a_addr = '0, pipe_b_addr = '0, ll_addr = '0;
  logic [31:0] pipe_a_data = '0, pipe_b_data = '0, ll_data = '0;
  logic        ll_ready, we_a, we_b, stall_req, proto_err;
  logic [4:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b;

  int n_checks = 0;
  int n_fail = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rstn(rstn),
    .pipe_a_valid(pipe_a_valid), .pipe_a_addr(pipe_a_addr), .pipe_a_data(pipe_a_data),
    .pipe_b_valid(pipe_b_valid), .pipe_b_addr(pipe_b_addr), .pipe_b_data(pipe_b_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .stall_req(stall_req), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a held result with its age in cycles since acceptance.
  bit          m_held = 0, n_held = 0;
  logic [4:0]  m_addr = '0, n_addr = '0;
  logic [31:0] m_data = '0, n_data = '0;
  int          m_age = 0, n_age = 0;
  bit          m_proto = 0, n_proto = 0;

  logic        e_we_a, e_we_b, e_rdy, e_stall;
  logic [4:0]  e_wa, e_wb;
  logic [31:0] e_da, e_db;
  bit          rel, stale;

  // Compute expected outputs from the rules, compare, and prepare next state.
  always @(negedge clk) begin
    e_we_a  = pipe_a_valid && (pipe_a_addr != 0);
    e_wa    = pipe_a_addr;
    e_da    = pipe_a_data;
    e_we_b  = pipe_b_valid && (pipe_b_addr != 0);
    e_wb    = pipe_b_addr;
    e_db    = pipe_b_data;
    e_rdy   = !m_held;
    e_stall = m_held && (m_age == LIMIT + 1);
    rel     = 0;
    if (m_held) begin
      stale = (pipe_a_valid && pipe_a_addr != 0 && pipe_a_addr == m_addr) ||
              (pipe_b_valid && pipe_b_addr != 0 && pipe_b_addr == m_addr);
      if (stale) begin
        rel = 1;
      end else if (e_stall || !pipe_a_valid) begin
        e_we_a = 1; e_wa = m_addr; e_da = m_data; rel = 1;
      end else if (!pipe_b_valid) begin
        e_we_b = 1; e_wb = m_addr; e_db = m_data; rel = 1;
      end
    end
    if (!rstn) begin
      e_we_a = 0; e_wa = 0; e_da = 0;
      e_we_b = 0; e_wb = 0; e_db = 0;
      e_rdy = 0;
    end
    chk("m_we_a", we_a, e_we_a);
    chk("m_waddr_a", waddr_a, e_wa);
    chk("m_wdata_a", wdata_a, e_da);
    chk("m_we_b", we_b, e_we_b);
    chk("m_waddr_b", waddr_b, e_wb);
    chk("m_wdata_b", wdata_b, e_db);
    chk("m_ll_ready", ll_ready, e_rdy);
    chk("m_stall_req", stall_req, e_stall);
    chk("m_proto_err", proto_err, m_proto);

    n_held = m_held; n_addr = m_addr; n_data = m_data; n_age = m_age; n_proto = m_proto;
    if (!rstn) begin
      n_held = 0; n_addr = 0; n_data = 0; n_age = 0; n_proto = 0;
    end else begin
      if (e_stall && pipe_a_valid) n_proto = 1;
      if (m_held) begin
        n_held = !rel;
        n_age  = m_age + 1;
      end else if (ll_valid && ll_addr != 0) begin
        n_held = 1; n_age = 1; n_addr = ll_addr; n_data = ll_data;
      end
    end
  end

  // Advance the model at the active edge.
  always @(posedge clk) begin
    m_held  <= n_held;
    m_addr  <= n_addr;
    m_data  <= n_data;
    m_age   <= n_age;
    m_proto <= n_proto;
  end

  // One cycle of stimulus; returns at the falling edge for literal checks.
  task automatic drive(input bit rs,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    rstn = rs;
    pipe_a_valid = av; pipe_a_addr = aa; pipe_a_data = ad;
    pipe_b_valid = bv; pipe_b_addr = ba; pipe_b_data = bd;
    ll_valid = lv; ll_addr = la; ll_data = ld;
    @(negedge clk);
    $display("cyc t=%0t rstn=%0b A=%0b/%0d B=%0b/%0d LL=%0b/%0d -> we_a=%0b wa=%0d we_b=%0b wb=%0d rdy=%0b stall=%0b perr=%0b",
             $time, rs, av, aa, bv, ba, lv, la, we_a, waddr_a, we_b, waddr_b, ll_ready, stall_req, proto_err);
  endtask

  task automatic idle(input bit rs);
    drive(rs, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic busy(input bit lv, input logic [4:0] la, input logic [31:0] ld);
    drive(1, 1, 1, 32'h101, 1, 2, 32'h202, lv, la, ld);
  endtask

  initial begin
    // Reset with everything requested: outputs must be forced low.
    drive(0, 1, 3, 32'h11, 1, 4, 32'h22, 1, 5, 32'h33);
    chk("rst_we_a", we_a, 0);
    chk("rst_we_b", we_b, 0);
    chk("rst_wdata_a", wdata_a, 0);
    chk("rst_ll_ready", ll_ready, 0);
    idle(0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_stall", stall_req, 0);
    idle(1);
    chk("idle_ll_ready", ll_ready, 1);

    // Both pipes pass through; LL waits behind busy pipes, retires on a.
    drive(1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0);
    chk("pass_we_a", we_a, 1);
    chk("pass_waddr_a", waddr_a, 3);
    chk("pass_wdata_a", wdata_a, 32'h11);
    chk("pass_waddr_b", waddr_b, 4);
    chk("pass_wdata_b", wdata_b, 32'h22);
    drive(1, 1, 3, 32'h11, 1, 4, 32'h22, 1, 5, 32'h33);
    chk("offer_ll_ready", ll_ready, 1);
    repeat (2) begin
      drive(1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0);
      chk("held_ll_ready", ll_ready, 0);
      chk("held_waddr_a", waddr_a, 3);
    end
    drive(1, 0, 0, 0, 1, 4, 32'h22, 0, 0, 0);
    chk("retire_we_a", we_a, 1);
    chk("retire_waddr_a", waddr_a, 5);
    chk("retire_wdata_a", wdata_a, 32'h33);
    chk("retire_waddr_b", waddr_b, 4);
    idle(1);
    chk("after_retire_ready", ll_ready, 1);
    chk("after_retire_we_a", we_a, 0);

    // Kill: pipe B writes the held register.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77);
    drive(1, 1, 2, 32'h2, 1, 7, 32'h70, 0, 0, 0);
    chk("kill_we_b", we_b, 1);
    chk("kill_wdata_b", wdata_b, 32'h70);
    chk("kill_waddr_a", waddr_a, 2);
    idle(1);
    chk("kill_no_write_a", we_a, 0);
    chk("kill_ll_ready", ll_ready, 1);

    // Starvation with pipe A behaving: force cycle 9 cycles after accept.
    busy(1, 9, 32'h99);
    repeat (LIMIT) begin
      busy(0, 0, 0);
      chk("starve_no_stall", stall_req, 0);
    end
    drive(1, 0, 0, 0, 1, 2, 32'h202, 0, 0, 0);
    chk("force_stall", stall_req, 1);
    chk("force_we_a", we_a, 1);
    chk("force_waddr_a", waddr_a, 9);
    chk("force_wdata_a", wdata_a, 32'h99);
    idle(1);
    chk("force_after_stall", stall_req, 0);
    chk("force_proto_ok", proto_err, 0);
    chk("force_after_ready", ll_ready, 1);

    // r0 suppression for pipe A and for a long-latency result.
    drive(1, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0);
    chk("r0_we_a", we_a, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAA);
    chk("r0_ll_offer_ready", ll_ready, 1);
    idle(1);
    chk("r0_ll_no_we_a", we_a, 0);
    chk("r0_ll_ready_back", ll_ready, 1);

    // Starvation with pipe A misbehaving during the stall cycle.
    busy(1, 10, 32'hA0);
    repeat (LIMIT) busy(0, 0, 0);
    busy(0, 0, 0);
    chk("viol_stall", stall_req, 1);
    chk("viol_waddr_a", waddr_a, 10);
    chk("viol_wdata_a", wdata_a, 32'hA0);
    idle(1);
    chk("viol_proto_set", proto_err, 1);
    repeat (3) idle(1);
    chk("viol_proto_sticky", proto_err, 1);

    // Reset while holding: held result is discarded for good.
    busy(1, 12, 32'hCC);
    busy(0, 0, 0);
    idle(0);
    chk("hold_rst_we_a", we_a, 0);
    chk("hold_rst_ready", ll_ready, 0);
    idle(0);
    chk("hold_rst_proto", proto_err, 0);
    chk("hold_rst_stall", stall_req, 0);
    idle(1);
    chk("hold_rel_we_a", we_a, 0);
    chk("hold_rel_ready", ll_ready, 1);
    repeat (3) idle(1);
    chk("hold_rel_never", we_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
